// File: rtl/axi_pkg.sv
// Shared definitions for the master/slave link: occupancy states and default sizes.
package axi_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/slave_fifo.sv
// Receive buffer storage with wrapping read/write pointers; head entry read combinationally.
module slave_fifo
    import axi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage is deliberately not reset; a write is suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/slave_logic.sv
// Receive-side slave: handshake, occupancy FSM, stall-stability check, buffer.
// Optional accepted-beat counter rx_cnt enabled by SLAVE_LOGIC_BYTE_CNT_EN.
module slave_logic
    import axi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] s_out_data,
    output logic              s_out_valid,
    input  logic              s_out_ready,
    output logic              s_err
`ifdef SLAVE_LOGIC_BYTE_CNT_EN
    ,
    output logic [15:0]       rx_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    occ_state_t        state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              push;
    logic              pop;
    logic              stalled;
    logic [DATA_W-1:0] stall_data;

    assign push        = m_valid & s_ready;
    assign pop         = s_out_valid & s_out_ready;
    assign s_out_valid = (count != '0);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            state   <= EMPTY;
            s_ready <= 1'b1;
        end else begin
            count   <= count_nxt;
            s_ready <= (count_nxt < FULL_CNT);
            unique case (state)
                EMPTY: begin
                    if (push) state <= PARTIAL;
                end
                PARTIAL: begin
                    if (push && !pop && count == FULL_CNT - 1'b1) begin
                        state <= FULL;
                    end else if (pop && !push && count == CNT_W'(1)) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) state <= PARTIAL;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // A beat offered but not taken must be re-offered unchanged on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_err   <= 1'b0;
            stalled <= 1'b0;
        end else begin
            stalled    <= m_valid & ~s_ready;
            stall_data <= m_s_data;
            if (stalled && (!m_valid || m_s_data != stall_data)) begin
                s_err <= 1'b1;
            end
        end
    end

`ifdef SLAVE_LOGIC_BYTE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt <= '0;
        end else if (push) begin
            rx_cnt <= rx_cnt + 16'd1;
        end
    end
`endif

    slave_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (m_s_data),
        .rd_data (s_out_data)
    );

endmodule

// File: tb/tb_slave_logic.sv
// Self-checking bench for slave_logic: directed scenarios plus a randomized run against a queue model.
module tb_slave_logic;
    import axi_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_s_data = '0;
    logic              s_ready;
    logic [DATA_W-1:0] s_out_data;
    logic              s_out_valid;
    logic              s_out_ready = 1'b0;
    logic              s_err;
`ifdef SLAVE_LOGIC_BYTE_CNT_EN
    logic [15:0]       rx_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] q [$];

    slave_logic #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_s_data    (m_s_data),
        .s_ready     (s_ready),
        .s_out_data  (s_out_data),
        .s_out_valid (s_out_valid),
        .s_out_ready (s_out_ready),
        .s_err       (s_err)
`ifdef SLAVE_LOGIC_BYTE_CNT_EN
        ,
        .rx_cnt      (rx_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_valid = 1'b0;
        s_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_s_out_valid: got %b expected 0", s_out_valid); end
        n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL reset_s_err: got %b expected 0", s_err); end
        n_cmp++; if (dut.count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
        n_cmp++; if (dut.state !== EMPTY) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dut.state, EMPTY); end
`ifdef SLAVE_LOGIC_BYTE_CNT_EN
        n_cmp++; if (rx_cnt !== 16'd0) begin n_err++; $display("FAIL reset_rx_cnt: got %0d expected 0", rx_cnt); end
`endif
    endtask

    task automatic test_in_order();
        logic [DATA_W-1:0] exp;
        do_reset();
        s_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = DATA_W'(8'hB0 + i);
            m_valid = 1'b1;
            m_s_data = exp;
            n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL inorder_s_ready[%0d]: got %b expected 1", i, s_ready); end
            step();
            n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== exp) begin
                n_err++; $display("FAIL inorder_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, s_out_valid, s_out_data, exp);
            end
        end
        m_valid = 1'b0;
        step();
        n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL inorder_drained: got %b expected 0", s_out_valid); end
        s_out_ready = 1'b0;
    endtask

    // Fill to FULL with B0..B3, then hold B4 at the master; drain one and check order.
    task automatic test_fill_drain();
        logic [DATA_W-1:0] exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid = 1'b1;
            m_s_data = DATA_W'(8'hB0 + i);
            step();
        end
        m_s_data = 8'hB4;
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_s_ready: got %b expected 0", s_ready); end
        n_cmp++; if (dut.state !== FULL) begin n_err++; $display("FAIL full_state: got %0d expected %0d", dut.state, FULL); end
        step();
        n_cmp++; if (dut.count !== 3'd4 || s_ready !== 1'b0) begin
            n_err++; $display("FAIL full_hold: got count=%0d rdy=%b expected count=4 rdy=0", dut.count, s_ready);
        end
        n_cmp++; if (s_out_data !== 8'hB0) begin n_err++; $display("FAIL full_head: got %h expected b0", s_out_data); end
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        n_cmp++; if (s_ready !== 1'b1 || dut.state !== PARTIAL) begin
            n_err++; $display("FAIL drain_one: got rdy=%b state=%0d expected rdy=1 state=%0d", s_ready, dut.state, PARTIAL);
        end
        step();
        m_valid = 1'b0;
        n_cmp++; if (dut.count !== 3'd4 || s_ready !== 1'b0) begin
            n_err++; $display("FAIL refill: got count=%0d rdy=%b expected count=4 rdy=0", dut.count, s_ready);
        end
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = DATA_W'(8'hB1 + i);
            n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== exp) begin
                n_err++; $display("FAIL drain_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, s_out_valid, s_out_data, exp);
            end
            step();
        end
        s_out_ready = 1'b0;
        n_cmp++; if (s_out_valid !== 1'b0 || s_err !== 1'b0) begin
            n_err++; $display("FAIL drain_end: got v=%b err=%b expected v=0 err=0", s_out_valid, s_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1;
            m_s_data = DATA_W'(8'hA0 + i);
            step();
        end
        rst = 1'b1;
        m_s_data = 8'hB6;
        s_out_ready = 1'b1;
        step();
        rst = 1'b0;
        m_valid = 1'b0;
        s_out_ready = 1'b0;
        n_cmp++; if (dut.count !== '0 || s_out_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL midreset: got count=%0d v=%b rdy=%b expected 0 0 1", dut.count, s_out_valid, s_ready);
        end
        m_valid = 1'b1;
        m_s_data = 8'hB7;
        step();
        m_valid = 1'b0;
        n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 8'hB7 || dut.count !== 3'd1) begin
            n_err++; $display("FAIL midreset_next: got v=%b d=%h count=%0d expected v=1 d=b7 count=1", s_out_valid, s_out_data, dut.count);
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid = 1'b1;
            m_s_data = DATA_W'(8'hB0 + i);
            step();
        end
        m_s_data = 8'hB4;
        step();
        n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL err_stable_hold: got %b expected 0", s_err); end
        m_s_data = 8'hB5;
        step();
        n_cmp++; if (s_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", s_err); end
        m_valid = 1'b0;
        s_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        s_out_ready = 1'b0;
        n_cmp++; if (s_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", s_err); end
        do_reset();
        n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b expected 0", s_err); end
    endtask

`ifdef SLAVE_LOGIC_BYTE_CNT_EN
    task automatic test_counter();
        do_reset();
        s_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_valid = 1'b1;
            m_s_data = DATA_W'(8'hC0 + i);
            step();
        end
        m_valid = 1'b0;
        step();
        n_cmp++; if (rx_cnt !== 16'd6) begin n_err++; $display("FAIL rx_cnt: got %0d expected 6", rx_cnt); end
        s_out_ready = 1'b0;
    endtask
`endif

    // Protocol-respecting random master and consumer against a FIFO queue model.
    task automatic test_random();
        logic pend;
        logic exp_push;
        logic exp_pop;
        int   thr;
        do_reset();
        q.delete();
        pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                m_valid = ($urandom_range(0, 3) != 0);
                m_s_data = DATA_W'($urandom);
            end
            thr = ((c / 60) % 2 == 1) ? 8 : 2;
            s_out_ready = ($urandom_range(0, 9) < thr);
            n_cmp++; if (s_ready !== (q.size() < DEPTH)) begin
                n_err++; $display("FAIL rand_s_ready[%0d]: got %b expected %b", c, s_ready, (q.size() < DEPTH));
            end
            n_cmp++; if (s_out_valid !== (q.size() != 0)) begin
                n_err++; $display("FAIL rand_s_out_valid[%0d]: got %b expected %b", c, s_out_valid, (q.size() != 0));
            end
            if (q.size() != 0) begin
                n_cmp++; if (s_out_data !== q[0]) begin
                    n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", c, s_out_data, q[0]);
                end
            end
            n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL rand_s_err[%0d]: got %b expected 0", c, s_err); end
            exp_push = m_valid && (q.size() < DEPTH);
            exp_pop  = (q.size() != 0) && s_out_ready;
            if (exp_pop)  void'(q.pop_front());
            if (exp_push) q.push_back(m_s_data);
            pend = m_valid && !exp_push;
            step();
        end
        m_valid = 1'b0;
        s_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill_drain();
        test_reset_mid();
        test_protocol_err();
`ifdef SLAVE_LOGIC_BYTE_CNT_EN
        test_counter();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/slave_logic.md
SLAVE_LOGIC -- requirements
Module: slave_logic

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the receive buffer entries; legal values are powers of 2 from 2 to 16.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port m_valid, input, 1, asserted by the upstream master when a beat is offered.
REQ-006 SHALL have port m_s_data, input, DATA_W, the master-to-slave payload.
REQ-007 SHALL have port s_ready, output, 1, which tells the master that a beat can be accepted.
REQ-008 SHALL have port s_out_data, output, DATA_W, the head-of-buffer payload to the local consumer.
REQ-009 SHALL have port s_out_valid, output, 1, asserted when s_out_data holds a valid beat.
REQ-010 SHALL have port s_out_ready, input, 1, asserted by the consumer when it takes the head beat.
REQ-011 SHALL have port s_err, output, 1, a sticky flag for a master protocol violation.

Function
REQ-012 SHALL accept a beat on a clk edge where m_valid=1 and s_ready=1, and on that edge write m_s_data at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-013 SHALL pop the head beat on a clk edge where s_out_valid=1 and s_out_ready=1, and on that edge increment rd_ptr modulo DEPTH.
REQ-014 SHALL make the buffer first-word-fall-through: a beat accepted at edge N appears on s_out_data with s_out_valid=1 immediately after edge N, which is 1-cycle latency.
REQ-015 SHALL keep a count register of width clog2(DEPTH)+1; on the same edge, a push alone adds 1, a pop alone subtracts 1, and a push with a pop leaves count unchanged.
REQ-016 SHALL drive s_ready as a register equal to (next count < DEPTH); s_ready SHALL be low exactly while the buffer is full.
REQ-017 SHALL drive s_out_valid = (count != 0); s_out_data is don't-care while s_out_valid=0.
REQ-018 SHALL track occupancy with a state machine of states EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH).
REQ-019 SHALL make these state transitions: EMPTY->PARTIAL on a push; PARTIAL->FULL on a push with no pop at count=DEPTH-1; PARTIAL->EMPTY on a pop with no push at count=1; FULL->PARTIAL on a pop.
REQ-020 SHALL ignore m_valid while in FULL (s_ready=0), so no write occurs and there is no overflow.
REQ-021 SHALL hold in FULL when s_out_ready=1 at the same time; that edge pops only, and s_ready rises on the next cycle.
REQ-022 SHALL, in EMPTY, take a push while s_out_ready=1 as a push only, with no bypass; a pop is impossible because s_out_valid=0.
REQ-023 SHALL set s_err to 1 on the next edge when m_valid=1 and s_ready=0, and on the following cycle m_valid falls or m_s_data changes (a stall stability violation); s_err SHALL stay 1 until reset.
REQ-024 SHALL wrap rd_ptr and wr_ptr from DEPTH-1 to 0 with no lost or duplicated beat.

Reset
REQ-025 SHALL, on a clk edge with rst=1, clear wr_ptr, rd_ptr and count to 0, set state to EMPTY, set s_ready=1 and s_out_valid=0, and clear s_err to 0.
REQ-026 SHALL discard buffered beats when reset is asserted mid-transfer; no beat is accepted or popped on that edge.
REQ-027 SHALL not reset buffer memory contents.

Configuration
REQ-028 SHALL, when macro SLAVE_LOGIC_BYTE_CNT_EN is defined, add output rx_cnt [15:0], which counts accepted beats, wraps 16'hFFFF->0, and is cleared by rst.
REQ-029 SHALL, when SLAVE_LOGIC_BYTE_CNT_EN is undefined, have no rx_cnt port and no counter logic, with all other behaviour identical.

Structure
REQ-030 SHALL place the state enum (EMPTY/PARTIAL/FULL) and default DATA_W/DEPTH constants in shared package axi_pkg, which master_logic also uses.
REQ-031 SHALL implement the buffer storage and pointers as one sub-module, slave_fifo; slave_logic holds the handshake, state machine, error check and counter.

Verification
REQ-032 SHALL test in-order delivery: with s_out_ready=1 and master sending 8'hB0..8'hB5 one per cycle, the bench SHALL see s_out_data B0..B5 in order, each 1 cycle after acceptance, with s_ready held at 1.
REQ-033 SHALL test fill to full: with s_out_ready=0, after 4 beats B0..B3 are accepted s_ready=0, B4 is held at the master, and the state is FULL.
REQ-034 SHALL test drain on full: from FULL, raising s_out_ready for 1 cycle pops B0 and s_ready=1 the next cycle, then B4 is accepted and output order is B1,B2,B3,B4.
REQ-035 SHALL test reset: asserting rst with 3 beats buffered gives count=0, s_out_valid=0 and s_ready=1 after that edge, and the next beat B7 is the next output.
REQ-036 SHALL test the protocol violation: while s_ready=0, changing m_s_data from B4 to B5 with m_valid=1 gives s_err=1, and it stays 1 until rst.
REQ-037 SHALL test the counter: with SLAVE_LOGIC_BYTE_CNT_EN defined, after 6 accepted beats rx_cnt=6.
